// File: rtl/alu_sched_pkg.sv
// Shared types for the ALU request scheduler: FSM states, function-group codes and an
// ID width helper.
package alu_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  localparam logic [1:0] GRP_ARITH = 2'b00;
  localparam logic [1:0] GRP_LOGIC = 2'b01;
  localparam logic [1:0] GRP_CMP   = 2'b10;
  localparam logic [1:0] GRP_SHIFT = 2'b11;

  function automatic int unsigned id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after 'last', wrapping.
module rr_arbiter
  import alu_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IdW     = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdW-1:0]     last,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IdW-1:0]     gnt_idx,
  output logic               gnt_valid
);

  logic [IdW-1:0] idx_k;

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx_k     = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx_k = IdW'((32'(last) + i) % NUM_REQ);
      if (!gnt_valid && req[idx_k]) begin
        gnt_valid  = 1'b1;
        gnt[idx_k] = 1'b1;
        gnt_idx    = idx_k;
      end
    end
  end

endmodule

// File: rtl/alu_req_sched.sv
// Round-robin scheduler sharing one ALU between NUM_REQ requesters, one op in flight.
// Define ALU_REQ_SCHED_FLAG_CHECK_EN to flag responses whose group flag was clear.
module alu_req_sched
  import alu_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned WIDTHA   = 16,
  parameter int unsigned WIDTHART = 32,
  parameter int unsigned ALU_LAT  = 1
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*WIDTHA-1:0]   req_a,
  input  logic [NUM_REQ*WIDTHA-1:0]   req_b,
  input  logic [NUM_REQ*4-1:0]        req_fun,
  output logic [WIDTHA-1:0]           alu_a,
  output logic [WIDTHA-1:0]           alu_b,
  output logic [3:0]                  alu_fun,
  input  logic [WIDTHART-1:0]         alu_arith_out,
  input  logic [WIDTHA-1:0]           alu_logic_out,
  input  logic [WIDTHA-1:0]           alu_cmp_out,
  input  logic [WIDTHA-1:0]           alu_shift_out,
  input  logic                        alu_carry,
  input  logic [3:0]                  alu_flags,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [id_w(NUM_REQ)-1:0]    rsp_id,
  output logic [WIDTHART-1:0]         rsp_data,
  output logic                        rsp_carry,
  output logic                        rsp_err
);

  localparam int unsigned IdW = id_w(NUM_REQ);

  state_e               state_q, state_d;
  logic [IdW-1:0]       last_q, op_id_q, rsp_id_q, gnt_idx;
  logic [NUM_REQ-1:0]   gnt;
  logic                 gnt_valid, accept, capture;
  logic [WIDTHA-1:0]    op_a_q, op_b_q;
  logic [3:0]           op_fun_q;
  logic [2:0]           cnt_q;
  logic [WIDTHART-1:0]  rsp_data_q, res_sel;
  logic                 rsp_carry_q, carry_sel;
  logic [1:0]           grp;
  logic [WIDTHA-1:0]    a_arr [NUM_REQ];
  logic [WIDTHA-1:0]    b_arr [NUM_REQ];
  logic [3:0]           f_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*WIDTHA +: WIDTHA];
    assign b_arr[i] = req_b[i*WIDTHA +: WIDTHA];
    assign f_arr[i] = req_fun[i*4 +: 4];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IdW     (IdW)
  ) u_arb (
    .req       (req_valid),
    .last      (last_q),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always_ff @(posedge CLK) begin
    if (RST) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (gnt_valid) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (cnt_q == 3'd0) state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = gnt;
        accept    = gnt_valid;
      end
      StWait:  capture = (cnt_q == 3'd0);
      StResp:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign grp = op_fun_q[3:2];

  always_comb begin
    res_sel   = '0;
    carry_sel = 1'b0;
    unique case (grp)
      GRP_ARITH: begin
        res_sel   = alu_arith_out;
        carry_sel = alu_carry;
      end
      GRP_LOGIC: res_sel = WIDTHART'(alu_logic_out);
      GRP_CMP:   res_sel = WIDTHART'(alu_cmp_out);
      GRP_SHIFT: res_sel = WIDTHART'(alu_shift_out);
      default:   res_sel = '0;
    endcase
  end

  // Operand registers feed the ALU directly so its inputs only move on a grant.
  always_ff @(posedge CLK) begin
    if (RST) begin
      last_q      <= IdW'(NUM_REQ - 1);
      op_id_q     <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_fun_q    <= '0;
      cnt_q       <= '0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
    end else begin
      if (accept) begin
        op_a_q   <= a_arr[gnt_idx];
        op_b_q   <= b_arr[gnt_idx];
        op_fun_q <= f_arr[gnt_idx];
        op_id_q  <= gnt_idx;
        last_q   <= gnt_idx;
      end
      if (state_q == StIssue) begin
        cnt_q <= 3'(ALU_LAT - 1);
      end else if (state_q == StWait && cnt_q != 3'd0) begin
        cnt_q <= cnt_q - 3'd1;
      end
      if (capture) begin
        rsp_id_q    <= op_id_q;
        rsp_data_q  <= res_sel;
        rsp_carry_q <= carry_sel;
      end
    end
  end

`ifdef ALU_REQ_SCHED_FLAG_CHECK_EN
  logic rsp_err_q;

  always_ff @(posedge CLK) begin
    if (RST)          rsp_err_q <= 1'b0;
    else if (capture) rsp_err_q <= ~alu_flags[grp];
  end

  assign rsp_err = rsp_err_q;
`else
  logic unused_flags;
  assign unused_flags = ^alu_flags;
  assign rsp_err      = 1'b0;
`endif

  assign alu_a     = op_a_q;
  assign alu_b     = op_b_q;
  assign alu_fun   = op_fun_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_carry = rsp_carry_q;

endmodule

// File: tb/tb_alu_req_sched.sv
// Scoreboard bench for alu_req_sched: behavioural ALU, round-robin reference and response queue.
module tb_alu_req_sched;

  localparam int unsigned NR  = 4;
  localparam int unsigned WA  = 16;
  localparam int unsigned WR  = 32;
  localparam int unsigned LAT = 1;
  localparam int unsigned IDW = 2;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic [NR-1:0]   req_valid, req_ready;
  logic [NR*WA-1:0] req_a, req_b;
  logic [NR*4-1:0] req_fun;
  logic [WA-1:0]   alu_a, alu_b;
  logic [3:0]      alu_fun;
  logic [WR-1:0]   alu_arith_out;
  logic [WA-1:0]   alu_logic_out, alu_cmp_out, alu_shift_out;
  logic            alu_carry;
  logic [3:0]      alu_flags;
  logic            rsp_valid, rsp_ready;
  logic [IDW-1:0]  rsp_id;
  logic [WR-1:0]   rsp_data;
  logic            rsp_carry, rsp_err;

  always #5 CLK = ~CLK;

  alu_req_sched #(
    .NUM_REQ  (NR),
    .WIDTHA   (WA),
    .WIDTHART (WR),
    .ALU_LAT  (LAT)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_fun       (req_fun),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_fun       (alu_fun),
    .alu_arith_out (alu_arith_out),
    .alu_logic_out (alu_logic_out),
    .alu_cmp_out   (alu_cmp_out),
    .alu_shift_out (alu_shift_out),
    .alu_carry     (alu_carry),
    .alu_flags     (alu_flags),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_data      (rsp_data),
    .rsp_carry     (rsp_carry),
    .rsp_err       (rsp_err)
  );

  typedef struct packed {
    logic [WR-1:0] arith;
    logic [WA-1:0] lg;
    logic [WA-1:0] cm;
    logic [WA-1:0] sh;
    logic          carry;
    logic [3:0]    flags;
  } alu_bus_t;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [WR-1:0]  data;
    logic           carry;
    logic           err;
  } rsp_t;

  // Every unit computes every cycle, as a real ALU would; flag k drops when a[k]&b[k].
  function automatic alu_bus_t alu_model(input logic [WA-1:0] a, input logic [WA-1:0] b,
                                         input logic [3:0] f);
    alu_bus_t r;
    logic [WA:0] s;
    s = {1'b0, a} + {1'b0, b};
    r.carry = s[WA];
    case (f[1:0])
      2'd0:    r.arith = WR'(a) + WR'(b);
      2'd1:    r.arith = WR'(a) - WR'(b);
      2'd2:    r.arith = WR'(a) * WR'(b);
      default: r.arith = {16'hA5A5, a ^ b};
    endcase
    case (f[1:0])
      2'd0:    r.lg = a & b;
      2'd1:    r.lg = a | b;
      2'd2:    r.lg = a ^ b;
      default: r.lg = ~a;
    endcase
    case (f[1:0])
      2'd0:    r.cm = WA'(a == b);
      2'd1:    r.cm = WA'(a < b);
      2'd2:    r.cm = WA'(a > b);
      default: r.cm = WA'(a != b);
    endcase
    case (f[1:0])
      2'd0:    r.sh = a << b[3:0];
      2'd1:    r.sh = a >> b[3:0];
      2'd2:    r.sh = WA'($signed(a) >>> b[3:0]);
      default: r.sh = {a[WA-2:0], a[WA-1]};
    endcase
    for (int k = 0; k < 4; k++) r.flags[k] = ~(a[k] & b[k]);
    return r;
  endfunction

  function automatic rsp_t ref_rsp(input int id, input logic [WA-1:0] a,
                                   input logic [WA-1:0] b, input logic [3:0] f);
    rsp_t r;
    alu_bus_t bus;
    bus     = alu_model(a, b, f);
    r.id    = IDW'(id);
    r.carry = 1'b0;
    case (f[3:2])
      2'd0: begin
        r.data  = bus.arith;
        r.carry = bus.carry;
      end
      2'd1:    r.data = WR'(bus.lg);
      2'd2:    r.data = WR'(bus.cm);
      default: r.data = WR'(bus.sh);
    endcase
`ifdef ALU_REQ_SCHED_FLAG_CHECK_EN
    r.err = ~bus.flags[f[3:2]];
`else
    r.err = 1'b0;
`endif
    return r;
  endfunction

  alu_bus_t pipe [LAT];
  always @(posedge CLK) begin
    pipe[0] <= alu_model(alu_a, alu_b, alu_fun);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign {alu_arith_out, alu_logic_out, alu_cmp_out, alu_shift_out, alu_carry, alu_flags} =
      pipe[LAT-1];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // Monitor / scoreboard state
  rsp_t          exp_q[$];
  int            rsp_log[$];
  bit            mon_en   = 1'b0;
  bit            inflight = 1'b0;
  int            ref_last = NR - 1;
  int            cyc      = 0;
  int            gcyc     = 0;
  int            gk       = 0;
  logic [NR-1:0] expv;
  logic [NR-1:0] gnt_seen = '0;
  logic [WA-1:0] cur_a = '0, cur_b = '0;
  logic [3:0]    cur_f = '0;

  always @(negedge CLK) begin
    cyc++;
    gnt_seen = req_ready & req_valid;
    if (mon_en) begin
      if (inflight) begin
        chk("alu_a_hold", 64'(alu_a), 64'(cur_a));
        chk("alu_b_hold", 64'(alu_b), 64'(cur_b));
        chk("alu_fun_hold", 64'(alu_fun), 64'(cur_f));
      end
      expv = '0;
      if (!inflight) begin
        for (int i = 1; i <= int'(NR); i++) begin
          int k;
          k = (ref_last + i) % NR;
          if (expv == '0 && req_valid[k]) begin
            expv[k] = 1'b1;
            gk      = k;
          end
        end
      end
      chk("req_ready", 64'(req_ready), 64'(expv));
      if (expv != '0) begin
        cur_a = req_a[gk*WA +: WA];
        cur_b = req_b[gk*WA +: WA];
        cur_f = req_fun[gk*4 +: 4];
        exp_q.push_back(ref_rsp(gk, cur_a, cur_b, cur_f));
        ref_last = gk;
        inflight = 1'b1;
        gcyc     = cyc;
      end
      if (inflight && cyc == gcyc + int'(LAT) + 2) chk("rsp_latency", 64'(rsp_valid), 64'(1));
      if (rsp_valid) begin
        if (exp_q.size() == 0 || cyc < gcyc + int'(LAT) + 2) begin
          chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
        end else begin
          chk("rsp_id", 64'(rsp_id), 64'(exp_q[0].id));
          chk("rsp_data", 64'(rsp_data), 64'(exp_q[0].data));
          chk("rsp_carry", 64'(rsp_carry), 64'(exp_q[0].carry));
          chk("rsp_err", 64'(rsp_err), 64'(exp_q[0].err));
          if (rsp_ready) begin
            rsp_log.push_back(int'(rsp_id));
            void'(exp_q.pop_front());
            inflight = 1'b0;
          end
        end
      end
      if (RST) begin
        exp_q.delete();
        inflight = 1'b0;
        ref_last = NR - 1;
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [WA-1:0] a,
                         input logic [WA-1:0] b, input logic [3:0] f);
    req_valid[i]         = v;
    req_a[i*WA +: WA]    = a;
    req_b[i*WA +: WA]    = b;
    req_fun[i*4 +: 4]    = f;
  endtask

  task automatic rand_op(input int i);
    logic [WA-1:0] a, b;
    a = ($urandom_range(0, 3) == 0) ? WA'($urandom_range(0, 15)) : WA'($urandom);
    b = ($urandom_range(0, 3) == 0) ? WA'($urandom_range(0, 15)) : WA'($urandom);
    set_req(i, 1'b1, a, b, 4'($urandom));
  endtask

  task automatic issue(input int i, input logic [WA-1:0] a, input logic [WA-1:0] b,
                       input logic [3:0] f);
    set_req(i, 1'b1, a, b, f);
    for (int n = 0; n < 50; n++) begin
      step();
      if (gnt_seen[i]) break;
    end
    chk("grant_seen", 64'(gnt_seen[i]), 64'(1));
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 200; n++) begin
      if (!inflight && exp_q.size() == 0 && !rsp_valid) break;
      step();
    end
    chk("idle_reached", 64'(inflight), 64'(0));
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    step();
    RST = 1'b0;
  endtask

  int exp_order[6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_fun   = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_alu_a", 64'(alu_a), 64'(0));
    chk("rst_alu_b", 64'(alu_b), 64'(0));
    chk("rst_alu_fun", 64'(alu_fun), 64'(0));
    chk("rst_rsp_id", 64'(rsp_id), 64'(0));
    chk("rst_rsp_data", 64'(rsp_data), 64'(0));
    chk("rst_rsp_carry", 64'(rsp_carry), 64'(0));
    chk("rst_rsp_err", 64'(rsp_err), 64'(0));
    @(posedge CLK);
    #1;
    RST    = 1'b0;
    mon_en = 1'b1;
    repeat (3) step();

    // Single add from requester 2
    rsp_ready = 1'b1;
    issue(2, 16'h0005, 16'h0003, 4'b0000);
    wait_idle();

    // Fairness with every requester active from reset
    pulse_reset();
    rsp_log.delete();
    for (int i = 0; i < int'(NR); i++) rand_op(i);
    for (int n = 0; n < 200 && rsp_log.size() < 8; n++) begin
      step();
      for (int i = 0; i < int'(NR); i++) if (gnt_seen[i]) rand_op(i);
    end
    for (int j = 0; j < 6; j++)
      chk("fair_order", 64'((rsp_log.size() > j) ? rsp_log[j] : -1), 64'(exp_order[j]));
    req_valid = '0;
    wait_idle();

    // Backpressure on a logic op with another requester waiting
    rsp_ready = 1'b0;
    issue(1, 16'h00F0, 16'h0FF0, 4'b0100);
    set_req(3, 1'b1, 16'h1111, 16'h2222, 4'b0001);
    for (int n = 0; n < 20; n++) begin
      if (rsp_valid) break;
      step();
    end
    for (int n = 0; n < 5; n++) begin
      step();
      chk("bp_valid", 64'(rsp_valid), 64'(1));
      chk("bp_data", 64'(rsp_data), 64'(32'h0000_00F0));
      chk("bp_no_grant", 64'(req_ready), 64'(0));
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_regrant", 64'(req_ready), 64'(4'b1000));
    step();
    req_valid[3] = 1'b0;
    wait_idle();

    // Compare op whose group flag is clear
    issue(1, 16'h0004, 16'h0004, 4'b1000);
    wait_idle();

    // Reset while the op is waiting on the ALU
    issue(0, 16'h1234, 16'h0001, 4'b0000);
    step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    for (int n = 0; n < 6; n++) begin
      chk("midop_no_rsp", 64'(rsp_valid), 64'(0));
      step();
    end

    // Randomised traffic with backpressure and abandoned requests
    for (int n = 0; n < 600; n++) begin
      step();
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < int'(NR); i++) begin
        if (gnt_seen[i]) begin
          if ($urandom_range(0, 1) == 0) rand_op(i);
          else req_valid[i] = 1'b0;
        end else if (req_valid[i]) begin
          if ($urandom_range(0, 19) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          rand_op(i);
        end
      end
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle();
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_req_sched.md
Name: alu_req_sched

Overview:
- Shares one ALU_TOP instance between NUM_REQ requesters via a round-robin arbiter with a valid/ready handshake on every port.
- Drives A/B/ALU_FUN into the ALU and waits ALU_LAT cycles for the registered result.
- Selects the output bus matching the function group and returns it on a single response channel, tagged with the requester ID.
- Sits between the requester clients and ALU_TOP, one instance per ALU.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTHA, 16, operand width (matches ALU widtha).
- WIDTHART, 32, arithmetic result / response data width.
- ALU_LAT, 1, cycles from ALU input change to valid registered output (1..4).

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*WIDTHA  packed operand A, requester i at [i*WIDTHA +: WIDTHA].
- req_b  in  NUM_REQ*WIDTHA  packed operand B.
- req_fun  in  NUM_REQ*4  packed ALU_FUN codes.
- alu_a, alu_b  out  WIDTHA  operands to ALU.
- alu_fun  out  4  function code to ALU.
- alu_arith_out  in  WIDTHART  signed arithmetic result.
- alu_logic_out, alu_cmp_out, alu_shift_out  in  WIDTHA  unit results.
- alu_carry  in  1  carry_out.
- alu_flags  in  4  {shift,cmp,logic,arith} unit flags.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  $clog2(NUM_REQ)  ID of the originating requester.
- rsp_data  out  WIDTHART  result.
- rsp_carry  out  1  carry, valid for the arithmetic group only, else 0.
- rsp_err  out  1  flag-check error (see Optional Feature).

Behaviour:
- Reset values: all outputs 0; state IDLE; RR pointer last=NUM_REQ-1, so requester 0 has highest priority.
- Group decode uses fun[3:2]: 00 arith, 01 logic, 10 cmp, 11 shift.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid, grant the first valid index after last (wrapping).
  - req_ready[g]=1 combinationally in that same cycle; transfer occurs then.
  - Latch a/b/fun/id into the operand registers; last<=g; go to ISSUE.
  - req_ready is 0 in every other state.
- ISSUE:
  - alu_a/alu_b/alu_fun are driven from the operand registers.
  - Start the wait counter at ALU_LAT-1; go to WAIT.
  - alu_* hold their values until the next grant and are never changed mid-operation.
- WAIT:
  - Decrement the counter.
  - At 0, capture the result into the response registers and go to RESP.
  - Result selection: arith = alu_arith_out unchanged; logic/cmp/shift = unit output zero-extended to WIDTHART.
  - rsp_carry = alu_carry for the arith group, else 0.
  - Latency from grant to rsp_valid is ALU_LAT+2 cycles.
- RESP:
  - rsp_valid=1; response fields stable while rsp_ready=0.
  - On rsp_valid&&rsp_ready, go to IDLE.
  - A new grant is possible in the following cycle (no back-to-back overlap; one op in flight).
- Boundaries:
  - Requester dropping req_valid before grant: no effect and no grant.
  - Single active requester: it is re-granted every op.
  - All requesters active: grant order strictly 0,1,..,N-1,0.
  - rsp_ready held low indefinitely: the block stalls in RESP and no new grants occur.
  - RST in any state: immediate return to reset values next edge; any in-flight op is dropped with no response.

Optional Feature:
- Macro ALU_REQ_SCHED_FLAG_CHECK_EN.
- When defined: at capture, the alu_flags bit of the decoded group is sampled. If it is 0, rsp_err=1 for that response (data still returned), else 0.
- When undefined: rsp_err is tied to 0 and no flag logic exists; alu_flags is unused.

Decomposition:
- Package alu_sched_pkg: FSM state enum, group encoding constants (GRP_ARITH=2'b00, GRP_LOGIC=2'b01, GRP_CMP=2'b10, GRP_SHIFT=2'b11), function ID width helper.
- One sub-module, rr_arbiter: NUM_REQ-wide round-robin grant from request vector plus last pointer, purely combinational, one-hot grant plus encoded index.
- FSM, wait counter and result mux live in the top.

Test Plan:
- Reset then idle: RST high 2 cycles -> all outputs 0, req_ready=0 with no requests.
- Single op, ALU_LAT=1, req 2 sends a=0x0005 b=0x0003 fun=4'b0000 (add) -> req_ready[2] pulses 1 cycle; alu_* =5/3/0 from ISSUE; rsp_valid 3 cycles after grant with rsp_id=2, rsp_data=8, rsp_carry from ALU.
- Fairness: all 4 req_valid held high, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1; no requester granted twice before the others.
- Backpressure: logic op 0x00F0&0x0FF0, rsp_ready=0 for 5 cycles -> rsp_valid held with rsp_data=0x000000F0 stable; req_ready all 0; after rsp_ready, one grant the next cycle.
- Mid-op reset: assert RST in WAIT -> next cycle state IDLE, rsp_valid=0, no response ever issued for that op.
- Flag check (macro on), ALU model holding cmp_flag=0 on a cmp op -> rsp_err=1 with cmp data; with macro off, rsp_err=0.
